// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU replacement and flush.
// One outstanding line refill; hits to resident lines are served meanwhile.
module icache_assoc #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128,
    parameter int WORD_W = 32,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              read_rqst_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] data_o,
    output logic              hit_o,
    output logic              miss_o,
    output logic              rqst_to_mem_o,
    output logic [ADDR_W-1:0] addr_to_mem_o,
    input  logic              mem_data_ready_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic [ADDR_W-1:0] mem_addr_i
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int WPL    = LINE_W / WORD_W;
    localparam int BOFF_W = $clog2(WORD_W / 8);
    localparam int SEL_W  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [LINE_W-1:0] line_data_q [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [SETS-1:0]   lru_q;

    logic [LA_W-1:0]   line_q;
    logic [LINE_W-1:0] buf_q;
    logic              rqst_q, rqst_d;
    logic              discard_q, discard_d;
    logic              latch, accept, install;

    logic [IDX_W-1:0]  idx, fidx;
    logic [TAG_W-1:0]  tag, ftag;
    logic [SEL_W-1:0]  wsel;
    logic              hit_any;
    logic [WAY_W-1:0]  hit_way, victim;
    logic [LINE_W-1:0] hline;
    logic              unused_bits;

    assign idx  = addr_i[OFF_W +: IDX_W];
    assign tag  = addr_i[ADDR_W-1 -: TAG_W];
    assign fidx = line_q[0 +: IDX_W];
    assign ftag = line_q[LA_W-1 -: TAG_W];

    if (WPL > 1) begin : g_sel
        assign wsel = addr_i[BOFF_W +: SEL_W];
    end else begin : g_nosel
        assign wsel = '0;
    end

    assign unused_bits = ^{addr_i[BOFF_W-1:0], mem_addr_i[OFF_W-1:0]};

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hline  = line_data_q[idx][hit_way];
    assign hit_o  = read_rqst_i & hit_any;
    assign miss_o = read_rqst_i & ~hit_any;
    assign data_o = hit_o ? hline[wsel*WORD_W +: WORD_W] : '0;

    // Victim: first invalid way, otherwise the way LRU points at.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = '0;
        if (WAYS > 1) victim = WAY_W'(lru_q[fidx]);
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[fidx][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rqst_d    = 1'b0;
        discard_d = discard_q;
        latch     = 1'b0;
        accept    = 1'b0;
        install   = 1'b0;
        unique case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (read_rqst_i && !hit_any && !flush_i) begin
                    latch   = 1'b1;
                    rqst_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) discard_d = 1'b1;
                if (mem_data_ready_i &&
                    mem_addr_i[ADDR_W-1:OFF_W] == line_q) begin
                    accept = 1'b1;
                    if (discard_q || flush_i) begin
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                install   = !flush_i;
                discard_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rqst_q    <= 1'b0;
            discard_q <= 1'b0;
            line_q    <= '0;
            lru_q     <= '0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q   <= state_d;
            rqst_q    <= rqst_d;
            discard_q <= discard_d;
            if (latch) line_q <= addr_i[ADDR_W-1:OFF_W];
            if (flush_i) begin
                lru_q <= '0;
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (install) begin
                valid_q[fidx][victim] <= 1'b1;
                lru_q[fidx]           <= ~victim[0];
            end else if (state_q == IDLE && hit_o) begin
                lru_q[idx] <= ~hit_way[0];
            end
        end
    end

    // Line storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (accept) buf_q <= mem_data_i;
        if (install) begin
            line_data_q[fidx][victim] <= buf_q;
            tag_q[fidx][victim]       <= ftag;
        end
    end

    assign rqst_to_mem_o = rqst_q;
    assign addr_to_mem_o = {line_q, {OFF_W{1'b0}}};

endmodule

// File: tb/tb_icache_assoc.sv
// Random and directed stimulus for icache_assoc against a recency-list
// model of resident lines and the refill protocol.
module tb_icache_assoc;
    localparam int AW = 20;
    localparam int LW = 128;
    localparam int WW = 32;
    localparam int NS = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] addr_i;
    logic          read_rqst_i;
    logic          flush_i;
    logic [WW-1:0] data_o;
    logic          hit_o;
    logic          miss_o;
    logic          rqst_to_mem_o;
    logic [AW-1:0] addr_to_mem_o;
    logic          mem_data_ready_i;
    logic [LW-1:0] mem_data_i;
    logic [AW-1:0] mem_addr_i;

    always #5 clk = ~clk;

    icache_assoc #(
        .ADDR_W(AW), .LINE_W(LW), .WORD_W(WW), .SETS(NS), .WAYS(NW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .addr_i(addr_i),
        .read_rqst_i(read_rqst_i),
        .flush_i(flush_i),
        .data_o(data_o),
        .hit_o(hit_o),
        .miss_o(miss_o),
        .rqst_to_mem_o(rqst_to_mem_o),
        .addr_to_mem_o(addr_to_mem_o),
        .mem_data_ready_i(mem_data_ready_i),
        .mem_data_i(mem_data_i),
        .mem_addr_i(mem_addr_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int unsigned ln,
                                             input int unsigned w);
        return 32'hDDCCBBAA ^ (ln * 32'h9E3779B1) ^ (w * 32'h01010101);
    endfunction

    function automatic logic [LW-1:0] line_data(input int unsigned ln);
        logic [LW-1:0] d;
        for (int w = 0; w < LW / WW; w++) d[w*WW +: WW] = mem_word(ln, w);
        return d;
    endfunction

    // Model: per set, resident line tags in recency order (MRU first)
    int unsigned   rec [NS][$];
    bit            waiting, filling, pulse, disc;
    int unsigned   want, fill_ln;
    logic [AW-1:0] mem_req;
    logic          obs_hit, obs_rqst;
    logic [WW-1:0] obs_data;

    function automatic int find(input int unsigned s, input int unsigned tg);
        for (int i = 0; i < rec[s].size(); i++)
            if (rec[s][i] == tg) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) rec[s].delete();
    endtask

    task automatic model_install(input int unsigned ln);
        int unsigned s, tg;
        s  = ln % NS;
        tg = ln / NS;
        if (rec[s].size() == NW) void'(rec[s].pop_back());
        rec[s].push_front(tg);
    endtask

    task automatic step(input logic rq, input logic [AW-1:0] a,
                        input logic fl, input logic rs,
                        input logic rdy, input logic [AW-1:0] ma);
        int unsigned ln, s, tg;
        int          pos;
        bit          res;
        read_rqst_i      = rq;
        addr_i           = a;
        flush_i          = fl;
        rst_i            = rs;
        mem_data_ready_i = rdy;
        mem_addr_i       = ma;
        mem_data_i       = line_data(int'(ma >> 4));
        @(negedge clk);
        ln  = int'(a >> 4);
        s   = ln % NS;
        tg  = ln / NS;
        pos = find(s, tg);
        res = (pos >= 0);
        obs_hit  = hit_o;
        obs_data = data_o;
        obs_rqst = rqst_to_mem_o;
        check("hit", hit_o, rq && res);
        check("miss", miss_o, rq && !res);
        check("data", data_o,
              (rq && res) ? mem_word(ln, (int'(a) >> 2) % 4) : 32'h0);
        check("rqst", rqst_to_mem_o, pulse);
        check("maddr", addr_to_mem_o, mem_req);
        if (rs) begin
            model_clear();
            waiting = 0;
            filling = 0;
            pulse   = 0;
            disc    = 0;
            mem_req = '0;
        end else begin
            pulse = 0;
            if (filling) begin
                filling = 0;
                if (!fl) model_install(fill_ln);
            end else if (waiting) begin
                if (rdy && int'(ma >> 4) == want) begin
                    waiting = 0;
                    if (!(disc || fl)) begin
                        filling = 1;
                        fill_ln = want;
                    end
                    disc = 0;
                end else if (fl) begin
                    disc = 1;
                end
            end else if (rq && !res && !fl) begin
                waiting = 1;
                want    = ln;
                pulse   = 1;
                mem_req = AW'(ln << 4);
            end else if (rq && res && !fl) begin
                rec[s].delete(pos);
                rec[s].push_front(tg);
            end
            if (fl) model_clear();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [AW-1:0] a);
        step(1, a, 0, 0, 0, '0);
        step(0, a, 0, 0, 0, '0);
        step(0, a, 0, 0, 1, a);
        step(0, a, 0, 0, 0, '0);
        step(0, a, 0, 0, 0, '0);
    endtask

    initial begin
        logic [AW-1:0] ra, rma;
        logic          rrq, rfl, rrs, rrdy;
        int unsigned   tg;

        rst_i = 1; read_rqst_i = 0; flush_i = 0; addr_i = '0;
        mem_data_ready_i = 0; mem_addr_i = '0; mem_data_i = '0;
        waiting = 0; filling = 0; pulse = 0; disc = 0; mem_req = '0;
        want = 0; fill_ln = 0;
        @(posedge clk);
        #1;
        step(0, '0, 0, 1, 0, '0);

        // Cold miss, refill, then word 1 of the same line
        step(1, 20'h00040, 0, 0, 0, '0);
        step(1, 20'h00040, 0, 0, 0, '0);
        check("t1_pulse", obs_rqst, 1'b1);
        step(0, 20'h00040, 0, 0, 0, '0);
        step(0, '0, 0, 0, 1, 20'h00040);
        step(1, 20'h00044, 0, 0, 0, '0);
        check("t1_fill_cycle", obs_hit, 1'b0);
        step(1, 20'h00044, 0, 0, 0, '0);
        check("t1_hit", obs_hit, 1'b1);
        check("t1_word", obs_data, mem_word(4, 1));

        // Wrong-line response ignored while waiting
        step(1, 20'h00080, 0, 0, 0, '0);
        step(0, '0, 0, 0, 1, 20'h10000);
        step(0, '0, 0, 0, 0, '0);
        step(0, '0, 0, 0, 1, 20'h00080);
        step(0, '0, 0, 0, 0, '0);
        step(1, 20'h00088, 0, 0, 0, '0);
        check("t3_hit", obs_hit, 1'b1);

        // LRU eviction in set 1
        fill(20'h00010);
        fill(20'h00050);
        step(1, 20'h00010, 0, 0, 0, '0);
        fill(20'h00090);
        step(1, 20'h00010, 0, 0, 0, '0);
        check("t2_a_hit", obs_hit, 1'b1);
        step(1, 20'h00050, 0, 0, 0, '0);
        check("t2_b_evicted", obs_hit, 1'b0);
        step(0, '0, 0, 0, 1, 20'h00050);
        step(0, '0, 0, 0, 0, '0);
        step(0, '0, 0, 0, 0, '0);

        // Hit under miss, flush in IDLE, flush in WAIT
        step(0, '0, 1, 0, 0, '0);
        fill(20'h00000);
        step(1, 20'h00040, 0, 0, 0, '0);
        step(1, 20'h00004, 0, 0, 0, '0);
        check("t4_hum", obs_hit, 1'b1);
        step(0, '0, 0, 0, 1, 20'h00040);
        step(0, '0, 0, 0, 0, '0);
        step(0, '0, 1, 0, 0, '0);
        step(1, 20'h00000, 0, 0, 0, '0);
        check("t5_flush_idle", obs_hit, 1'b0);
        step(0, '0, 1, 0, 0, '0);
        step(0, '0, 0, 0, 1, 20'h00000);
        step(0, '0, 0, 0, 0, '0);
        step(0, '0, 0, 0, 0, '0);
        step(1, 20'h00000, 0, 0, 0, '0);
        check("t5_flush_wait", obs_hit, 1'b0);

        // Reset while waiting, late response ignored
        step(0, '0, 0, 1, 0, '0);
        step(0, '0, 0, 0, 1, 20'h00000);
        check("t6_rqst", obs_rqst, 1'b0);
        step(0, '0, 0, 0, 0, '0);
        step(1, 20'h00000, 0, 0, 0, '0);
        check("t6_no_install", obs_hit, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            tg = $urandom_range(0, 5);
            if ($urandom_range(0, 15) == 0) tg = 32'h3FFF;
            ra   = AW'((tg << 6) | ($urandom_range(0, 3) << 4) |
                       ($urandom_range(0, 3) << 2));
            rrq  = ($urandom_range(0, 3) != 0);
            rfl  = ($urandom_range(0, 39) == 0);
            rrs  = ($urandom_range(0, 199) == 0);
            rrdy = 0;
            rma  = AW'($urandom);
            if (waiting && $urandom_range(0, 2) == 0) begin
                rrdy = 1;
                if ($urandom_range(0, 3) == 0)
                    rma = AW'(((want ^ $urandom_range(1, 7)) << 4) |
                              $urandom_range(0, 15));
                else
                    rma = AW'((want << 4) | $urandom_range(0, 15));
            end else if ($urandom_range(0, 7) == 0) begin
                rrdy = 1;
                rma  = AW'(($urandom_range(0, 95) << 4) |
                           $urandom_range(0, 15));
            end
            step(rrq, ra, rfl, rrs, rrdy, rma);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
